// File: rtl/sti_pi_feeder.sv
// sti_pi_feeder: fetches parallel words and format fields from a synchronous
// command ROM, presents them to the STI_DAC parallel interface with a
// one-cycle load strobe, and paces issue on completion of each serial burst.
// Each burst is checked against the length implied by pi_length, stalls in
// WAIT_HI abort the run, and pi_end marks the final word.
//
// Handshake: load is a one-cycle strobe. The pi_* fields are valid in the
// load cycle and held until the next load. The next word is issued only
// after so_valid has risen and then fallen again. There is no backpressure
// from STI_DAC beyond that burst.
module sti_pi_feeder #(
  parameter int N_WORDS = 35,
  parameter int ADDR_W  = 6,
  parameter int TIMEOUT = 64
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [31:0]       rom_data,
  output logic              load,
  output logic [15:0]       pi_data,
  output logic [1:0]        pi_length,
  output logic              pi_fill,
  output logic              pi_msb,
  output logic              pi_low,
  output logic              pi_end,
  input  logic              so_valid,
  output logic              busy,
  output logic              done,
  output logic              len_err,
  output logic              timeout_err,
  output logic [15:0]       bit_count,
  output logic [2:0]        state_dbg
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_ADDR    = 3'd1,
    S_DATA    = 3'd2,
    S_LOAD    = 3'd3,
    S_WAIT_HI = 3'd4,
    S_WAIT_LO = 3'd5,
    S_DONE    = 3'd6
  } state_t;

  localparam int                TO_W      = $clog2(TIMEOUT + 1);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(N_WORDS - 1);
  localparam logic [TO_W-1:0]   TO_LAST   = TO_W'(TIMEOUT - 1);

  state_t          state;
  logic [5:0]      burst_cnt;
  logic [TO_W-1:0] to_cnt;
  logic [5:0]      burst_exp;
  logic [5:0]      burst_inc;
  logic [15:0]     bits_inc;
  logic            unused_rom_bits;

  // Only the documented fields of the ROM word are used.
  assign unused_rom_bits = ^{rom_data[15:14], rom_data[11:9], rom_data[7:5], rom_data[3:1]};

  assign state_dbg = state;

  // Expected burst size and saturating increments for the two counters.
  always_comb begin
    burst_exp = {1'b0, pi_length, 3'b000} + 6'd8;
    burst_inc = (burst_cnt == 6'd63) ? burst_cnt : burst_cnt + 6'd1;
    bits_inc  = (bit_count == 16'hFFFF) ? bit_count : bit_count + 16'd1;
  end

  // Sequencer FSM: all outputs are registered and updated on state entry.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state       <= S_IDLE;
      rom_addr    <= '0;
      load        <= 1'b0;
      pi_data     <= '0;
      pi_length   <= '0;
      pi_fill     <= 1'b0;
      pi_msb      <= 1'b0;
      pi_low      <= 1'b0;
      pi_end      <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      len_err     <= 1'b0;
      timeout_err <= 1'b0;
      bit_count   <= '0;
      burst_cnt   <= '0;
      to_cnt      <= '0;
    end else begin
      load <= 1'b0;
      case (state)
        S_IDLE, S_DONE: begin
          if (start) begin
            rom_addr    <= '0;
            pi_end      <= 1'b0;
            done        <= 1'b0;
            len_err     <= 1'b0;
            timeout_err <= 1'b0;
            bit_count   <= '0;
            busy        <= 1'b1;
            state       <= S_ADDR;
          end
        end
        // ROM registers rom_addr here; its data is visible during DATA.
        S_ADDR: state <= S_DATA;
        S_DATA: begin
          pi_data   <= rom_data[31:16];
          pi_length <= rom_data[13:12];
          pi_fill   <= rom_data[8];
          pi_msb    <= rom_data[4];
          pi_low    <= rom_data[0];
          load      <= 1'b1;
          if (rom_addr == LAST_ADDR) pi_end <= 1'b1;
          state     <= S_LOAD;
        end
        S_LOAD: begin
          burst_cnt <= '0;
          to_cnt    <= '0;
          state     <= S_WAIT_HI;
        end
        S_WAIT_HI: begin
          if (so_valid) begin
            burst_cnt <= burst_inc;
            bit_count <= bits_inc;
            state     <= S_WAIT_LO;
          end else if (to_cnt == TO_LAST) begin
            // TIMEOUT idle cycles seen: abandon the remaining words.
            timeout_err <= 1'b1;
            done        <= 1'b1;
            busy        <= 1'b0;
            state       <= S_DONE;
          end else begin
            to_cnt <= to_cnt + TO_W'(1);
          end
        end
        S_WAIT_LO: begin
          if (so_valid) begin
            burst_cnt <= burst_inc;
            bit_count <= bits_inc;
          end else begin
            if (burst_cnt != burst_exp) len_err <= 1'b1;
            if (rom_addr == LAST_ADDR) begin
              done  <= 1'b1;
              busy  <= 1'b0;
              state <= S_DONE;
            end else begin
              rom_addr <= rom_addr + ADDR_W'(1);
              state    <= S_ADDR;
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sti_pi_feeder.sv
// Testbench for sti_pi_feeder: synchronous ROM model, STI_DAC burst driver,
// scoreboard queue of expected load-cycle fields, and a final report.
module tb_sti_pi_feeder;

  localparam int N  = 3;
  localparam int AW = 6;
  localparam int TO = 16;

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic [AW-1:0] rom_addr;
  logic [31:0]   rom_data;
  logic          load;
  logic [15:0]   pi_data;
  logic [1:0]    pi_length;
  logic          pi_fill;
  logic          pi_msb;
  logic          pi_low;
  logic          pi_end;
  logic          so_valid;
  logic          busy;
  logic          done;
  logic          len_err;
  logic          timeout_err;
  logic [15:0]   bit_count;
  logic [2:0]    state_dbg;

  sti_pi_feeder #(.N_WORDS(N), .ADDR_W(AW), .TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset), .start(start), .rom_addr(rom_addr),
    .rom_data(rom_data), .load(load), .pi_data(pi_data),
    .pi_length(pi_length), .pi_fill(pi_fill), .pi_msb(pi_msb),
    .pi_low(pi_low), .pi_end(pi_end), .so_valid(so_valid), .busy(busy),
    .done(done), .len_err(len_err), .timeout_err(timeout_err),
    .bit_count(bit_count), .state_dbg(state_dbg)
  );

  // Clock / synchronous command ROM
  always #5 clk = ~clk;

  logic [31:0] rom [0:63];
  always_ff @(posedge clk) rom_data <= rom[rom_addr];

  // Scoreboard: {rom_addr, pi_data, pi_length, pi_fill, pi_msb, pi_low, pi_end}
  logic [27:0] exp_q[$];
  int          n_assert = 0;
  int          n_fail   = 0;

  logic [31:0] wd [0:2];
  int          bl [0:2];
  int          model_bits;
  logic        model_lerr;
  logic        pulse_start_w1;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
    n_assert++;
    assert (obs === exp_v) else begin
      n_fail++;
      $error("FAIL %s: observed 'h%0h expected 'h%0h", tag, obs, exp_v);
    end
  endtask

  function automatic logic [31:0] mk_word(input logic [15:0] d, input logic [1:0] len,
                                          input logic f, input logic m, input logic l);
    logic [31:0] j;
    j = $urandom;
    return {d, j[1:0], len, j[4:2], f, j[7:5], m, j[10:8], l};
  endfunction

  task automatic push_one(input int i, input logic last);
    exp_q.push_back({6'(i), wd[i][31:16], wd[i][13:12], wd[i][8], wd[i][4], wd[i][0], last});
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_outs"}, {rom_addr, load, pi_data, pi_length, pi_fill, pi_msb, pi_low,
                           pi_end, busy, done, len_err, timeout_err, bit_count}, 64'd0);
    check({tag, "_state"}, state_dbg, 3'd0);
  endtask

  // Wait (bounded) for load; require 3-cycle latency and matching fields.
  task automatic wait_load(input string tag);
    int          lat;
    logic        seen;
    logic [27:0] e;
    lat  = 0;
    seen = 1'b0;
    while (!seen && lat < 40) begin
      @(negedge clk);
      start = 1'b0;
      lat++;
      seen = load;
    end
    check({tag, "_latency"}, {seen, lat[7:0]}, {1'b1, 8'd3});
    check({tag, "_q_nonempty"}, exp_q.size() != 0, 1'b1);
    e = (exp_q.size() != 0) ? exp_q.pop_front() : 28'h0;
    check({tag, "_fields"}, {rom_addr, pi_data, pi_length, pi_fill, pi_msb, pi_low, pi_end}, e);
  endtask

  // STI_DAC model: so_valid high for len cycles starting after the load cycle.
  task automatic drive_burst(input int len);
    for (int i = 0; i < len; i++) begin
      @(negedge clk);
      start    = 1'b0;
      so_valid = 1'b1;
    end
    @(negedge clk);
    start    = 1'b0;
    so_valid = 1'b0;
  endtask

  task automatic do_run(input string tag);
    model_bits = 0;
    model_lerr = 1'b0;
    for (int i = 0; i < N; i++) rom[i] = wd[i];
    @(negedge clk);
    start = 1'b1;
    for (int i = 0; i < N; i++) begin
      wait_load($sformatf("%s_w%0d", tag, i));
      check($sformatf("%s_w%0d_bits", tag, i), bit_count, 64'(model_bits));
      check($sformatf("%s_w%0d_lerr", tag, i), len_err, model_lerr);
      check($sformatf("%s_w%0d_terr", tag, i), timeout_err, 1'b0);
      check($sformatf("%s_w%0d_busy", tag, i), {busy, done}, 2'b10);
      if (i == 1 && pulse_start_w1) start = 1'b1;
      drive_burst(bl[i]);
      model_bits += bl[i];
      if (bl[i] != (int'(wd[i][13:12]) + 1) * 8) model_lerr = 1'b1;
    end
    @(negedge clk);
    check({tag, "_end_flags"}, {done, busy, pi_end, timeout_err}, 4'b1010);
    check({tag, "_end_lerr"}, len_err, model_lerr);
    check({tag, "_end_bits"}, bit_count, 64'(model_bits));
    check({tag, "_end_hold"}, pi_data, wd[N-1][31:16]);
    check({tag, "_end_state"}, state_dbg, 3'd6);
    check({tag, "_q_empty"}, exp_q.size(), 64'd0);
    // so_valid activity in DONE must not be counted
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      so_valid = 1'($urandom_range(0, 1));
    end
    @(negedge clk);
    so_valid = 1'b0;
    check({tag, "_done_ignore_bits"}, bit_count, 64'(model_bits));
    check({tag, "_done_hold"}, {done, busy}, 2'b10);
  endtask

  initial begin
    int   k;
    int   l2;
    logic seen_load;
    logic dn;

    reset          = 1'b0;
    start          = 1'b0;
    so_valid       = 1'b0;
    pulse_start_w1 = 1'b0;
    for (int i = 0; i < 64; i++) rom[i] = 32'h0;
    repeat (3) @(negedge clk);
    check_reset_state("reset_init");
    reset = 1'b1;

    // so_valid in IDLE is ignored
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      so_valid = 1'($urandom_range(0, 1));
    end
    @(negedge clk);
    so_valid = 1'b0;
    @(negedge clk);
    check("idle_ignore", {bit_count, busy, done}, 18'd0);
    check("idle_state", state_dbg, 3'd0);

    // Normal run: lengths 00/01/11, bursts 8/16/32
    wd[0] = mk_word(16'h1234, 2'b00, 1'b1, 1'b0, 1'b1);
    wd[1] = mk_word(16'($urandom), 2'b01, 1'b0, 1'b1, 1'b0);
    wd[2] = mk_word(16'hBEEF, 2'b11, 1'b1, 1'b1, 1'b0);
    bl[0] = 8; bl[1] = 16; bl[2] = 32;
    push_one(0, 1'b0); push_one(1, 1'b0); push_one(2, 1'b1);
    do_run("normal");
    check("normal_total", bit_count, 64'd56);
    check("normal_lerr", len_err, 1'b0);

    // Field mapping + length error + start pulsed while busy
    l2    = $urandom_range(0, 3);
    wd[0] = 32'hA5C3_2111;
    wd[1] = mk_word(16'h0F0F, 2'b01, 1'b1, 1'b0, 1'b0);
    wd[2] = mk_word(16'h5A5A, 2'(l2), 1'b0, 1'b0, 1'b1);
    bl[0] = 24; bl[1] = 15; bl[2] = (l2 + 1) * 8;
    exp_q.push_back({6'd0, 16'hA5C3, 2'b10, 1'b1, 1'b1, 1'b1, 1'b0});
    push_one(1, 1'b0); push_one(2, 1'b1);
    pulse_start_w1 = 1'b1;
    do_run("lenerr");
    pulse_start_w1 = 1'b0;
    check("lenerr_flag", len_err, 1'b1);
    check("lenerr_total", bit_count, 64'(24 + 15 + (l2 + 1) * 8));

    // Timeout: so_valid never rises
    wd[0]  = mk_word(16'h7777, 2'b10, 1'b0, 1'b0, 1'b1);
    rom[0] = wd[0];
    push_one(0, 1'b0);
    @(negedge clk);
    start = 1'b1;
    wait_load("tmo_w0");
    k         = 0;
    seen_load = 1'b0;
    dn        = 1'b0;
    while (!dn && k < TO + 20) begin
      @(negedge clk);
      k++;
      if (load) seen_load = 1'b1;
      dn = done;
    end
    check("tmo_cycles", 64'(k), 64'(TO + 1));
    check("tmo_flags", {timeout_err, done, busy, seen_load}, 4'b1100);
    check("tmo_bits", bit_count, 64'd0);
    check("tmo_state", state_dbg, 3'd6);

    // Reset during WAIT_LO of word 2, then a clean restart
    wd[0] = mk_word(16'h1111, 2'b00, 1'b0, 1'b1, 1'b1);
    wd[1] = mk_word(16'h2222, 2'b10, 1'b1, 1'b0, 1'b1);
    wd[2] = mk_word(16'h3333, 2'b01, 1'b1, 1'b1, 1'b1);
    for (int i = 0; i < N; i++) rom[i] = wd[i];
    push_one(0, 1'b0); push_one(1, 1'b0);
    @(negedge clk);
    start = 1'b1;
    wait_load("rst_w0");
    drive_burst(8);
    wait_load("rst_w1");
    @(negedge clk);
    so_valid = 1'b1;
    @(negedge clk);
    check("rst_pre_state", state_dbg, 3'd5);
    reset = 1'b0;
    @(negedge clk);
    check_reset_state("reset_mid");
    reset    = 1'b1;
    so_valid = 1'b0;
    bl[0] = 8; bl[1] = 24; bl[2] = 16;
    push_one(0, 1'b0); push_one(1, 1'b0); push_one(2, 1'b1);
    do_run("restart");
    check("restart_total", bit_count, 64'd48);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/sti_pi_feeder.md
# sti_pi_feeder

Upstream command sequencer for the STI_DAC serializer. It fetches parallel words and their per-word format fields from a synchronous command ROM, presents them on the STI_DAC parallel interface with a one-cycle `load` strobe, and waits for each serial burst on `so_valid` to complete before issuing the next word. It checks that every burst carries the number of bits implied by `pi_length`, flags stalls, and raises `pi_end` with the final word.

## Interface

Parameters:
- N_WORDS, 35: number of ROM entries issued per run (entries 0 to N_WORDS-1); must be 1 to 2^ADDR_W.
- ADDR_W, 6: ROM address width.
- TIMEOUT, 64: maximum cycles allowed in WAIT_HI with `so_valid` low before the run aborts.

Ports:
- clk, input, 1: single clock; all logic on the rising edge.
- reset, input, 1: synchronous, active-low reset.
- start, input, 1: run request, sampled only in IDLE.
- rom_addr, output, ADDR_W: command ROM address, registered.
- rom_data, input, 32: ROM word, valid one cycle after `rom_addr` changes.
  - [31:16] pi_data
  - [13:12] length
  - [8] fill
  - [4] msb
  - [0] low
  - all other bits ignored
- load, output, 1: one-cycle strobe to STI_DAC.
- pi_data, output, 16: registered; stable from the `load` cycle until the next `load`.
- pi_length, output, 2: same holding rule as `pi_data`.
- pi_fill, output, 1: same holding rule as `pi_data`.
- pi_msb, output, 1: same holding rule as `pi_data`.
- pi_low, output, 1: same holding rule as `pi_data`.
- pi_end, output, 1: set in the cycle of the last word's `load`; held until the next accepted `start` or reset.
- so_valid, input, 1: serial-burst valid from STI_DAC.
- busy, output, 1: high in every state except IDLE and DONE.
- done, output, 1: level; high in DONE, cleared by the next accepted `start`.
- len_err, output, 1: sticky burst-length mismatch flag.
- timeout_err, output, 1: sticky stall flag.
- bit_count, output, 16: total `so_valid`-high cycles counted in the current run; saturates at 16'hFFFF.

## Operation

- FSM states: IDLE, ADDR, DATA, LOAD, WAIT_HI, WAIT_LO, DONE.
- IDLE or DONE with `start`=1:
  - clear `rom_addr`, `pi_end`, `done`, `len_err`, `timeout_err` and `bit_count`;
  - go to ADDR.
- ADDR: `rom_addr` is stable; go to DATA.
- DATA: capture the `rom_data` fields into the `pi_*` registers; go to LOAD.
- LOAD:
  - `load`=1 for exactly this cycle;
  - `pi_end` is set in this cycle if `rom_addr`==N_WORDS-1;
  - clear the burst counter and the timeout counter; go to WAIT_HI.
- WAIT_HI:
  - `so_valid`=1: count this cycle and go to WAIT_LO.
  - `so_valid`=0: increment the timeout counter. When it reaches TIMEOUT, set `timeout_err` and go to DONE; the remaining words are not issued.
- WAIT_LO:
  - `so_valid`=1: count this cycle.
  - `so_valid`=0: the burst has ended. Compare the burst count with the expected count: 8 for length 00, 16 for 01, 24 for 10, 32 for 11. On mismatch set `len_err`; the run continues.
  - After the burst ends: if `rom_addr`==N_WORDS-1, go to DONE; otherwise increment `rom_addr` and go to ADDR.
- Counting: each counted cycle increments both the burst counter (6-bit, saturating at 63) and `bit_count`.
- `start` while `busy` is ignored. `so_valid` in IDLE or DONE is ignored and not counted.
- Reset (`reset`=0 at a clock edge, including mid-run): state IDLE. All outputs go to 0: `rom_addr`, `load`, all `pi_*`, `pi_end`, `busy`, `done`, `len_err`, `timeout_err`, `bit_count`.

## Timing

- `start` is sampled at edge E0. ADDR is active during cycle 1, DATA during cycle 2, and `load` is high during cycle 3. Start-to-first-load latency is 3 cycles.
- The `pi_*` values change only on the edge that enters LOAD, so they are valid in the `load` cycle.
- Burst end to next `load`: the edge that samples `so_valid`=0 in WAIT_LO enters ADDR. `load` is high 3 cycles after that edge.
- The final burst ends in DONE, with `done`=1 and `busy`=0 at the next edge. `pi_end` is already high at that point.
- Minimum per-word period: 3 + burst length + 1 cycles.
- `so_valid` high for exactly one cycle is a legal 1-bit burst: count 1, which mismatches every length, so `len_err` is set.
- A timeout uses exactly TIMEOUT idle cycles in WAIT_HI, followed by one edge into DONE.

## Test plan

- **Normal run:** N_WORDS=3; ROM lengths 00/01/11; a model of STI_DAC returns bursts of 8, 16 and 32 cycles. Required: three `load` pulses, each 3 cycles after start or after the previous burst end; `pi_end` rises with the third `load`; `bit_count`=56; `done`=1; `len_err`=0.
- **Field mapping:** ROM word 32'hA5C3_2111. Required in the `load` cycle: `pi_data`=16'hA5C3, `pi_length`=2'b10, `pi_fill`=1, `pi_msb`=1, `pi_low`=1.
- **Length error:** word 1 has length 01 and the model returns 15 cycles. Required: `len_err`=1 after that burst; the run continues to `done`; `bit_count`=15 plus the other bursts.
- **Timeout:** the model never asserts `so_valid`. Required: `timeout_err`=1 and `done`=1 exactly TIMEOUT+1 cycles after the first `load`; no second `load`.
- **Reset mid-run:** `reset`=0 during WAIT_LO of word 2. Required: next cycle all outputs are 0 and the state is IDLE. A new `start` restarts from `rom_addr`=0 with the flags cleared.
- **Ignored inputs:** `start` pulsed while `busy` and `so_valid` toggled in IDLE. Required: no restart and `bit_count` unchanged.
